key_cmd_decoder: RTL and testbench

Parametrised, registered successor to the calculator's keypad demultiplexer. It turns a held keypad code into single debounced events: a one-hot command strobe or level for operator/start keys, a digit strobe for numeric keys, or an unknown-key strobe. It sits between the keypad scanner and the calculator control FSM, and gives exactly one event per physical press, with a release hold-off.

---
 rtl/key_cmd_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_key_cmd_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_decoder.sv
// -----------------------------------------------------------------------------
// key_cmd_decoder
//
// Turns a held keypad code into single debounced events. Each physical press
// produces one event: a one-hot command (operator/start keys), a digit strobe
// (codes 0..DIGIT_MAX), or an unknown-key strobe. After a release, a hold-off
// must pass before the next press is accepted. Bounces during the hold-off are
// absorbed.
//
// Optional feature macro: KEY_REPEAT_EN
//   When defined, a continuously held key re-emits its event every REPEAT_DLY
//   cycles. When undefined, each press gives exactly one event.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   keypressed   in   [KEY_W]  key code from the scanner, valid with key_valid
//   key_valid    in   a key is currently held
//   clear        in   synchronous clear of the latched command (cmd_out only)
//   cmd_out      out  [N_CMD]  one-hot command (pulse or latched, by LATCH_MODE)
//   cmd_stb      out  1-cycle pulse on each command event
//   digit_stb    out  1-cycle pulse on each digit event
//   digit_val    out  [KEY_W]  last digit code, updated only with digit_stb
//   unknown_stb  out  1-cycle pulse for a code that is neither command nor digit
//   busy         out  FSM not in IDLE
// -----------------------------------------------------------------------------
module key_cmd_decoder #(
  parameter int                      KEY_W      = 4,
  parameter int                      N_CMD      = 3,
  parameter logic [N_CMD*KEY_W-1:0]  CMD_CODES  = {4'd15, 4'd11, 4'd10},
  parameter int                      DIGIT_MAX  = 9,
  parameter int                      HOLDOFF    = 4,
  parameter int                      LATCH_MODE = 0,
  parameter int                      REPEAT_DLY = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] keypressed,
  input  logic             key_valid,
  input  logic             clear,
  output logic [N_CMD-1:0] cmd_out,
  output logic             cmd_stb,
  output logic             digit_stb,
  output logic [KEY_W-1:0] digit_val,
  output logic             unknown_stb,
  output logic             busy
);

  localparam int CNT_W = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CMD-1:0]   cmd_out_q, cmd_out_d;
  logic               cmd_stb_q, cmd_stb_d;
  logic               digit_stb_q, digit_stb_d;
  logic [KEY_W-1:0]   digit_val_q, digit_val_d;
  logic               unknown_stb_q, unknown_stb_d;

  // Event request for this cycle and the code it decodes.
  logic               fire;
  logic [KEY_W-1:0]   dec_code;
  logic [N_CMD-1:0]   match;
  logic [N_CMD-1:0]   cmd_onehot;
  logic               is_cmd;
  logic               is_digit;

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DLY + 1);

  logic [RPT_W-1:0]   rpt_q, rpt_d;
  logic [KEY_W-1:0]   code_q, code_d;

  // A new press decodes the live input; repeats decode the latched code.
  assign dec_code = (state_q == IDLE) ? keypressed : code_q;
`else
  logic unused_repeat_dly;
  assign unused_repeat_dly = ^REPEAT_DLY;
  assign dec_code = keypressed;
`endif

  // Per-channel comparators.
  generate
    for (genvar gi = 0; gi < N_CMD; gi++) begin : g_match
      assign match[gi] = (dec_code == CMD_CODES[gi*KEY_W +: KEY_W]);
    end
  endgenerate

  // Isolate the lowest set bit so the lowest matching channel wins.
  assign cmd_onehot = match & (~match + N_CMD'(1));
  assign is_cmd     = |match;
  assign is_digit   = !is_cmd && (int'(dec_code) <= DIGIT_MAX);

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fire          = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d         = '0;
    code_d        = code_q;
`endif

    case (state_q)
      IDLE: begin
        if (key_valid) begin
          fire    = 1'b1;
          state_d = PRESS;
`ifdef KEY_REPEAT_EN
          code_d  = keypressed;
`endif
        end
      end
      PRESS: begin
        if (!key_valid) begin
          cnt_d   = CNT_W'(HOLDOFF - 1);
          state_d = RELEASE;
        end
`ifdef KEY_REPEAT_EN
        else if (rpt_q == RPT_W'(REPEAT_DLY - 1)) begin
          fire  = 1'b1;
          rpt_d = '0;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
`endif
      end
      RELEASE: begin
        // A high sample here is a bounce or early re-press: no event.
        if (key_valid) begin
          state_d = PRESS;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_stb_d     = fire && is_cmd;
    digit_stb_d   = fire && is_digit;
    unknown_stb_d = fire && !is_cmd && !is_digit;
    digit_val_d   = (fire && is_digit) ? dec_code : digit_val_q;

    if (LATCH_MODE != 0) begin
      // A command in the same cycle as clear takes precedence.
      if (fire && is_cmd) begin
        cmd_out_d = cmd_onehot;
      end else if (clear) begin
        cmd_out_d = '0;
      end else begin
        cmd_out_d = cmd_out_q;
      end
    end else begin
      cmd_out_d = (fire && is_cmd) ? cmd_onehot : '0;
    end
  end

  // Reset lands in RELEASE so a key held through reset yields no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RELEASE;
      cnt_q         <= CNT_W'(HOLDOFF - 1);
      cmd_out_q     <= '0;
      cmd_stb_q     <= 1'b0;
      digit_stb_q   <= 1'b0;
      digit_val_q   <= '0;
      unknown_stb_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q         <= '0;
      code_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_out_q     <= cmd_out_d;
      cmd_stb_q     <= cmd_stb_d;
      digit_stb_q   <= digit_stb_d;
      digit_val_q   <= digit_val_d;
      unknown_stb_q <= unknown_stb_d;
`ifdef KEY_REPEAT_EN
      rpt_q         <= rpt_d;
      code_q        <= code_d;
`endif
    end
  end

  assign cmd_out     = cmd_out_q;
  assign cmd_stb     = cmd_stb_q;
  assign digit_stb   = digit_stb_q;
  assign digit_val   = digit_val_q;
  assign unknown_stb = unknown_stb_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_key_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_cmd_decoder
//
// Drives two decoders (pulse mode and latched mode) with the same keypad
// stimulus. A behavioural model, written in terms of "consecutive low samples
// since the last high sample", predicts each cycle's outputs; the prediction is
// queued when the inputs are driven and compared after the next clock edge.
// -----------------------------------------------------------------------------
module tb_key_cmd_decoder;

  localparam int HOLD = 4;
  localparam int RDLY = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] keypressed;
  logic       key_valid;
  logic       clear;

  logic [2:0] cmd_out0, cmd_out1;
  logic       cmd_stb0, cmd_stb1;
  logic       digit_stb0, digit_stb1;
  logic [3:0] digit_val0, digit_val1;
  logic       unknown_stb0, unknown_stb1;
  logic       busy0, busy1;

  key_cmd_decoder #(
    .KEY_W(4), .N_CMD(3), .CMD_CODES({4'd15, 4'd11, 4'd10}), .DIGIT_MAX(9),
    .HOLDOFF(HOLD), .LATCH_MODE(0), .REPEAT_DLY(RDLY)
  ) u_dut_pulse (
    .clk(clk), .rst_n(rst_n), .keypressed(keypressed), .key_valid(key_valid),
    .clear(clear), .cmd_out(cmd_out0), .cmd_stb(cmd_stb0),
    .digit_stb(digit_stb0), .digit_val(digit_val0),
    .unknown_stb(unknown_stb0), .busy(busy0)
  );

  key_cmd_decoder #(
    .KEY_W(4), .N_CMD(3), .CMD_CODES({4'd15, 4'd11, 4'd10}), .DIGIT_MAX(9),
    .HOLDOFF(HOLD), .LATCH_MODE(1), .REPEAT_DLY(RDLY)
  ) u_dut_latch (
    .clk(clk), .rst_n(rst_n), .keypressed(keypressed), .key_valid(key_valid),
    .clear(clear), .cmd_out(cmd_out1), .cmd_stb(cmd_stb1),
    .digit_stb(digit_stb1), .digit_val(digit_val1),
    .unknown_stb(unknown_stb1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd0;
    logic [2:0] cmd1;
    logic       cstb;
    logic       dstb;
    logic       ustb;
    logic [3:0] dval;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  int n_vec;
  int n_err;

  // Model state.
  int         m_lowrun;   // consecutive low samples since the last high one
  int         m_held;     // high samples since the last event or re-entry
  logic [3:0] m_latched;
  logic [3:0] m_dval;
  logic [2:0] m_cmd1;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk_val("p.cmd_out",     int'(cmd_out0),     int'(e.cmd0));
    chk_val("p.cmd_stb",     int'(cmd_stb0),     int'(e.cstb));
    chk_val("p.digit_stb",   int'(digit_stb0),   int'(e.dstb));
    chk_val("p.digit_val",   int'(digit_val0),   int'(e.dval));
    chk_val("p.unknown_stb", int'(unknown_stb0), int'(e.ustb));
    chk_val("p.busy",        int'(busy0),        int'(e.busy));
    chk_val("l.cmd_out",     int'(cmd_out1),     int'(e.cmd1));
    chk_val("l.cmd_stb",     int'(cmd_stb1),     int'(e.cstb));
    chk_val("l.digit_stb",   int'(digit_stb1),   int'(e.dstb));
    chk_val("l.digit_val",   int'(digit_val1),   int'(e.dval));
    chk_val("l.unknown_stb", int'(unknown_stb1), int'(e.ustb));
    chk_val("l.busy",        int'(busy1),        int'(e.busy));
  endtask

  // Reset behaves as if one low sample has already been seen, so HOLDOFF more
  // low samples reach the accepting state.
  function automatic exp_t model_reset();
    exp_t e;
    m_lowrun  = 1;
    m_held    = 0;
    m_latched = 4'd0;
    m_dval    = 4'd0;
    m_cmd1    = 3'd0;
    e.cmd0 = 3'd0; e.cmd1 = 3'd0; e.cstb = 1'b0; e.dstb = 1'b0; e.ustb = 1'b0;
    e.dval = 4'd0; e.busy = 1'b1;
    return e;
  endfunction

  // One sampled cycle of the model.
  function automatic exp_t model_step(input logic kv, input logic [3:0] code,
                                      input logic clr);
    exp_t       e;
    logic       ev;
    logic [3:0] ev_code;
    logic [2:0] oh;
    ev      = 1'b0;
    ev_code = 4'd0;
    if (kv) begin
      if (m_lowrun >= HOLD + 1) begin
        ev = 1'b1; ev_code = code; m_latched = code; m_held = 0;
      end else if (m_lowrun == 0) begin
        m_held++;
`ifdef KEY_REPEAT_EN
        if (m_held == RDLY) begin
          ev = 1'b1; ev_code = m_latched; m_held = 0;
        end
`endif
      end else begin
        m_held = 0;
      end
      m_lowrun = 0;
    end else if (m_lowrun < HOLD + 1) begin
      m_lowrun++;
    end

    oh = 3'd0;
    e.cstb = 1'b0; e.dstb = 1'b0; e.ustb = 1'b0;
    if (ev) begin
      case (ev_code)
        4'd10:   oh = 3'b001;
        4'd11:   oh = 3'b010;
        4'd15:   oh = 3'b100;
        default: oh = 3'b000;
      endcase
      if (oh != 3'd0)          e.cstb = 1'b1;
      else if (ev_code <= 4'd9) begin e.dstb = 1'b1; m_dval = ev_code; end
      else                     e.ustb = 1'b1;
    end
    if (e.cstb)   m_cmd1 = oh;
    else if (clr) m_cmd1 = 3'd0;
    e.cmd0 = oh;
    e.cmd1 = m_cmd1;
    e.dval = m_dval;
    e.busy = (m_lowrun < HOLD + 1);
    return e;
  endfunction

  // Drive one cycle of inputs (called just after a negedge), queue the
  // prediction, then compare after the following posedge.
  task automatic step(input logic kv, input logic [3:0] code, input logic clr);
    exp_t e;
    key_valid  = kv;
    keypressed = code;
    clear      = clr;
    exp_q.push_back(model_step(kv, code, clr));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    $display("t=%0t kv=%0d key=%0d clr=%0d | cmd_p=%b cmd_l=%b c/d/u=%0d%0d%0d dval=%0d busy=%0d",
             $time, kv, code, clr, cmd_out0, cmd_out1, cmd_stb0, digit_stb0,
             unknown_stb0, digit_val0, busy0);
    compare_all(e);
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code, input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, code, 1'b0);
    for (int i = 0; i < lo; i++) step(1'b0, code, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Key held through reset: no event until a fresh press.
    rst_n      = 1'b0;
    key_valid  = 1'b1;
    keypressed = 4'd10;
    clear      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(model_reset());
    compare_all(exp_q.pop_front());
    rst_n = 1'b1;
    press(4'd10, 3, 5);
    press(4'd10, 3, 6);

    // Long hold of a command key, busy through the hold-off.
    press(4'd11, 6, 6);

    // Bounce inside the hold-off.
    press(4'd15, 1, 2);
    press(4'd15, 3, 6);

    // Digit then unknown key.
    press(4'd7, 2, 6);
    press(4'd12, 2, 6);

    // Latched commands, digit keeps the latch, clear with a command, clear alone.
    press(4'd15, 2, 6);
    press(4'd3, 2, 6);
    press(4'd10, 2, 6);
    step(1'b1, 4'd11, 1'b1);
    press(4'd11, 1, 6);
    step(1'b0, 4'd0, 1'b1);
    press(4'd0, 0, 2);

    // Every code once.
    for (int c = 0; c < 16; c++) press(4'(c), 1, 5);

    // Re-press exactly at the end of the hold-off, and one cycle too early.
    press(4'd9, 1, 4);
    press(4'd9, 1, 5);
    press(4'd0, 1, 5);

`ifdef KEY_REPEAT_EN
    press(4'd5, 30, 6);
`endif

    // Reset asserted mid-operation with a latched command present.
    press(4'd11, 2, 0);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(model_reset());
    compare_all(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    press(4'd11, 0, 5);
    press(4'd10, 1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
